// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic MAC array.
// Holds A and B, then streams them onto the west/north edges with diagonal skew.
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(N)-1:0]   wr_row,
  input  logic [$clog2(N)-1:0]   wr_col,
  input  logic [W-1:0]           wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [N*W-1:0]         west_out,
  output logic [N*W-1:0]         north_out
);

  localparam int AW = $clog2(N);
  localparam int TW = $clog2(3 * N);
  localparam logic [TW-1:0] TLAST = TW'(3 * N - 3);

  typedef enum logic {
    IDLE,
    FEED
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   t_q;
  logic [TW-1:0]   t_d;
  logic [W-1:0]    a_q [N][N];
  logic [W-1:0]    b_q [N][N];
  logic [N*W-1:0]  west_d;
  logic [N*W-1:0]  north_d;

  // Edge slices for the cycle about to be registered: row i sees A[i][t-i],
  // column j sees B[t-j][j]; anything outside the skew window is zero.
  always_comb begin
    t_d     = '0;
    west_d  = '0;
    north_d = '0;
    if (state_q == FEED) t_d = t_q + TW'(1);
    for (int i = 0; i < N; i++) begin
      if (int'(t_d) >= i && int'(t_d) - i < N) begin
        west_d[i*W +: W]  = a_q[i][AW'(int'(t_d) - i)];
        north_d[i*W +: W] = b_q[AW'(int'(t_d) - i)][i];
      end
    end
  end

  // Feed FSM with registered outputs; start outranks a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      t_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      west_out  <= '0;
      north_out <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FEED;
            t_q       <= '0;
            busy      <= 1'b1;
            west_out  <= west_d;
            north_out <= north_d;
          end else if (wr_en) begin
            if (wr_sel) b_q[wr_row][wr_col] <= wr_data;
            else        a_q[wr_row][wr_col] <= wr_data;
          end
        end
        FEED: begin
          if (t_q == TLAST) begin
            state_q   <= IDLE;
            t_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            west_out  <= '0;
            north_out <= '0;
          end else begin
            t_q       <= t_d;
            west_out  <= west_d;
            north_out <= north_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder.
// A behavioural 4x4 MAC array consumes the edge outputs to form C.
module tb_systolic_feeder;

  localparam int N = 4;
  localparam int W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic            wr_sel = 1'b0;
  logic [1:0]      wr_row = '0;
  logic [1:0]      wr_col = '0;
  logic [3:0]      wr_data = '0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic [15:0]     west_out;
  logic [15:0]     north_out;

  int checks = 0;
  int errors = 0;

  logic            arr_clr = 1'b0;
  logic [3:0]      pa  [N][N];
  logic [3:0]      pb  [N][N];
  logic [15:0]     acc [N][N];

  systolic_feeder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done),
    .west_out(west_out), .north_out(north_out)
  );

  always #5 clk = ~clk;

  // Output-stationary array: a moves east, b moves south, each PE accumulates.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [3:0] ain;
        logic [3:0] bin;
        if (j == 0) ain = west_out[i*W +: W];
        else        ain = pa[i][j-1];
        if (i == 0) bin = north_out[j*W +: W];
        else        bin = pb[i-1][j];
        if (arr_clr) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
          acc[i][j] <= acc[i][j] + 16'(ain) * 16'(bin);
        end
      end
    end
  end

  task automatic wr(input logic s, input int r, input int c, input int d);
    wr_en   = 1'b1;
    wr_sel  = s;
    wr_row  = 2'(r);
    wr_col  = 2'(c);
    wr_data = 4'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic clear_array();
    arr_clr = 1'b1;
    @(negedge clk);
    arr_clr = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (west_out !== 16'h0 || north_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_edges: west=%h north=%h want 0", west_out, north_out);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b want 0", busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    int bc;
    int dc;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, (r == c) ? 1 : 0);
        wr(1'b1, r, c, 4 * r + c);
      end
    clear_array();
    start_run();
    bc = 0;
    dc = 0;
    for (int k = 0; k < 14; k++) begin
      if (busy === 1'b1) bc++;
      if (done === 1'b1) begin
        dc++;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            checks++;
            if (acc[r][c] !== 16'(4 * r + c)) begin
              errors++;
              $display("FAIL identity_C[%0d][%0d]: got %0d want %0d",
                       r, c, acc[r][c], 4 * r + c);
            end
          end
      end
      @(negedge clk);
    end
    checks++;
    if (bc !== 10) begin
      errors++;
      $display("FAIL identity_busy_len: got %0d want 10", bc);
    end
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL identity_done_len: got %0d want 1", dc);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    start_run();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done=%b busy=%b want 1 0", done, busy);
    end
    arr_clr = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    arr_clr = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b want 1 0", busy, done);
    end
    k = 0;
    while (k < 15 && done !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k !== 10) begin
      errors++;
      $display("FAIL b2b_done_delay: got %0d want 10", k);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        checks++;
        if (acc[r][c] !== 16'(4 * r + c)) begin
          errors++;
          $display("FAIL b2b_C[%0d][%0d]: got %0d want %0d",
                   r, c, acc[r][c], 4 * r + c);
        end
      end
    @(negedge clk);
  endtask

  task automatic test_skew_and_ignored();
    logic [15:0] ew [10];
    logic [15:0] en [10];
    ew = '{16'h0001, 16'h0021, 16'h0321, 16'h4321, 16'h4320,
           16'h4300, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
    en = '{16'h0001, 16'h0012, 16'h0123, 16'h1234, 16'h2340,
           16'h3400, 16'h4000, 16'h0000, 16'h0000, 16'h0000};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, r + 1);
        wr(1'b1, r, c, r + 1);
      end
    start_run();
    for (int t = 0; t < 10; t++) begin
      checks++;
      if (west_out !== ew[t] || north_out !== en[t] || busy !== 1'b1) begin
        errors++;
        $display("FAIL skew_t%0d: west=%h north=%h busy=%b want %h %h 1",
                 t, west_out, north_out, busy, ew[t], en[t]);
      end
      if (t == 2) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_row  = 2'd0;
        wr_col  = 2'd0;
        wr_data = 4'd7;
      end
      if (t == 4) start = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || west_out !== 16'h0) begin
      errors++;
      $display("FAIL skew_end: done=%b busy=%b west=%h want 1 0 0",
               done, busy, west_out);
    end
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_row  = 2'd0;
    wr_col  = 2'd0;
    wr_data = 4'd9;
    start_run();
    wr_en = 1'b0;
    checks++;
    if (west_out !== 16'h0001) begin
      errors++;
      $display("FAIL start_prio_t0: west=%h want 0001", west_out);
    end
    repeat (11) @(negedge clk);
    start_run();
    checks++;
    if (west_out !== 16'h0001) begin
      errors++;
      $display("FAIL readback_A00: west=%h want 0001", west_out);
    end
    repeat (11) @(negedge clk);
  endtask

  task automatic test_max();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wr(1'b0, r, c, 15);
        wr(1'b1, r, c, 15);
      end
    clear_array();
    start_run();
    repeat (10) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL max_done: got %b want 1", done);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        checks++;
        if (acc[r][c] !== 16'd900) begin
          errors++;
          $display("FAIL max_C[%0d][%0d]: got %0d want 900", r, c, acc[r][c]);
        end
      end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (west_out !== 16'h0 || north_out !== 16'h0 ||
          busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL max_after_%0d: west=%h north=%h busy=%b done=%b want 0",
                 k, west_out, north_out, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    int bc;
    int nz;
    start_run();
    repeat (5) @(negedge clk);
    checks++;
    if (west_out !== 16'hFF00 || north_out !== 16'hFF00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_t5: west=%h north=%h busy=%b want ff00 ff00 1",
               west_out, north_out, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (west_out !== 16'h0 || north_out !== 16'h0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: west=%h north=%h busy=%b done=%b want 0",
               west_out, north_out, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    checks++;
    if (dc !== 0) begin
      errors++;
      $display("FAIL mid_no_done: got %0d want 0", dc);
    end
    start_run();
    bc = 0;
    nz = 0;
    repeat (12) begin
      if (busy === 1'b1) bc++;
      if (west_out !== 16'h0 || north_out !== 16'h0) nz++;
      @(negedge clk);
    end
    checks++;
    if (bc !== 10 || nz !== 0) begin
      errors++;
      $display("FAIL mid_cleared_run: busy_cycles=%0d nonzero=%0d want 10 0",
               bc, nz);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_skew_and_ignored();
    test_max();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
